// File: rtl/qeciphy_tx_aligngen.sv
`default_nettype none
// ============================================================================
// Module      : qeciphy_tx_aligngen
// Description : Transmit-side comma framer for the GT TX datapath. Emits a
//               K28.5 comma word in slot 0 of every PATTERN_PERIOD-word
//               period so the far-end byte aligner can find and keep the
//               word boundary. Once the far end reports alignment, user
//               words are multiplexed into the non-comma slots.
// Ports       : clk, rst_n      - TX user clock, async active-low reset
//               i_enable        - link enable (low forces IDLE)
//               i_tx_rdy        - GT TX ready (low forces IDLE)
//               i_align_done    - far-end alignment confirmed (level, clk domain)
//               i_tx_tdata/i_tx_tvalid/o_tx_tready - user word handshake
//               o_tx_data       - registered word to GT TXDATA
//               o_tx_charisk    - registered TXCHARISK (4'b0001 on comma)
//               o_aligning      - registered, high while in ALIGN
//               o_data_mode     - registered, high while in DATA
// Revision    : 1.0 - initial release
// ============================================================================
module qeciphy_tx_aligngen #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    PATTERN_PERIOD = 1024,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_tx_rdy,
  input  logic                  i_align_done,
  input  logic [DATA_WIDTH-1:0] i_tx_tdata,
  input  logic                  i_tx_tvalid,
  output logic                  o_tx_tready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [3:0]            o_tx_charisk,
  output logic                  o_aligning,
  output logic                  o_data_mode
);

  localparam int                    CNT_W      = $clog2(PATTERN_PERIOD);
  localparam logic [CNT_W-1:0]      LAST_SLOT  = CNT_W'(PATTERN_PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] COMMA_WORD = DATA_WIDTH'(32'h0000_00BC);
  localparam logic [3:0]            COMMA_K    = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] slot_cnt;
  logic             link_up;

  assign link_up = i_enable & i_tx_rdy;

  // Slot 0 always carries the comma, so the user is stalled there. The
  // enables are included directly so tready drops in the same cycle the
  // link goes down, before the state register catches up.
  assign o_tx_tready = (state == ST_DATA) & (slot_cnt != '0) & link_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      slot_cnt     <= '0;
      o_tx_data    <= IDLE_WORD;
      o_tx_charisk <= 4'b0000;
      o_aligning   <= 1'b0;
      o_data_mode  <= 1'b0;
    end else if (!link_up) begin
      // Link loss wins over everything, including mid-period aborts.
      state        <= ST_IDLE;
      slot_cnt     <= '0;
      o_tx_data    <= IDLE_WORD;
      o_tx_charisk <= 4'b0000;
      o_aligning   <= 1'b0;
      o_data_mode  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Counter stays at 0 so the first ALIGN word is the slot-0 comma.
          state        <= ST_ALIGN;
          slot_cnt     <= '0;
          o_tx_data    <= IDLE_WORD;
          o_tx_charisk <= 4'b0000;
          o_aligning   <= 1'b1;
          o_data_mode  <= 1'b0;
        end
        ST_ALIGN, ST_DATA: begin
          slot_cnt <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + CNT_W'(1);

          if (slot_cnt == '0) begin
            o_tx_data    <= COMMA_WORD;
            o_tx_charisk <= COMMA_K;
          end else if ((state == ST_DATA) && i_tx_tvalid) begin
            o_tx_data    <= i_tx_tdata;
            o_tx_charisk <= 4'b0000;
          end else begin
            o_tx_data    <= IDLE_WORD;
            o_tx_charisk <= 4'b0000;
          end

          // Switch to DATA only at the period boundary so the comma
          // cadence seen by the far end is never disturbed.
          if ((state == ST_ALIGN) && i_align_done && (slot_cnt == LAST_SLOT)) begin
            state       <= ST_DATA;
            o_aligning  <= 1'b0;
            o_data_mode <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          slot_cnt     <= '0;
          o_tx_data    <= IDLE_WORD;
          o_tx_charisk <= 4'b0000;
          o_aligning   <= 1'b0;
          o_data_mode  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qeciphy_tx_aligngen.sv
`default_nettype none
// ============================================================================
// Module      : tb_qeciphy_tx_aligngen
// Description : Self-checking bench for qeciphy_tx_aligngen. A short-period
//               instance (PATTERN_PERIOD=6) is compared cycle by cycle with
//               a behavioural framing model; a default-period instance is
//               driven by a simple far-end aligner model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qeciphy_tx_aligngen;

  localparam int          P      = 6;
  localparam logic [31:0] COMMA  = 32'h0000_00BC;
  localparam logic [31:0] IDLE_W = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, rdy, ad, tvalid;
  logic [31:0] tdata;
  logic        o_tx_tready, o_aligning, o_data_mode;
  logic [31:0] o_tx_data;
  logic [3:0]  o_tx_charisk;

  logic        en2, rdy2, ad2, tvalid2;
  logic [31:0] tdata2;
  logic        o2_tx_tready, o2_aligning, o2_data_mode;
  logic [31:0] o2_tx_data;
  logic [3:0]  o2_tx_charisk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qeciphy_tx_aligngen #(
    .DATA_WIDTH    (32),
    .PATTERN_PERIOD(P),
    .IDLE_WORD     (IDLE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enable    (en),
    .i_tx_rdy    (rdy),
    .i_align_done(ad),
    .i_tx_tdata  (tdata),
    .i_tx_tvalid (tvalid),
    .o_tx_tready (o_tx_tready),
    .o_tx_data   (o_tx_data),
    .o_tx_charisk(o_tx_charisk),
    .o_aligning  (o_aligning),
    .o_data_mode (o_data_mode)
  );

  qeciphy_tx_aligngen dut_long (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enable    (en2),
    .i_tx_rdy    (rdy2),
    .i_align_done(ad2),
    .i_tx_tdata  (tdata2),
    .i_tx_tvalid (tvalid2),
    .o_tx_tready (o2_tx_tready),
    .o_tx_data   (o2_tx_data),
    .o_tx_charisk(o2_tx_charisk),
    .o_aligning  (o2_aligning),
    .o_data_mode (o2_data_mode)
  );

  // --------------------------------------------------------------------------
  // Reference model: link is "active" from the cycle after enables are seen;
  // m_n is the position within the comma period of the word about to be
  // emitted; m_data records that the far end confirmed alignment at a period
  // end. Expected outputs are the word emitted at the last edge.
  // --------------------------------------------------------------------------
  bit          m_active, m_data, m_took;
  int          m_n;
  logic [31:0] e_data;
  logic [3:0]  e_k;
  logic        e_al, e_dm, e_rdy;

  assign e_rdy = m_data && (m_n != 0) && en && rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_data = 0; m_took = 0; m_n = 0;
      e_data = IDLE_W; e_k = 4'h0; e_al = 0; e_dm = 0;
    end else begin
      m_took = 0;
      if (!(en && rdy)) begin
        m_active = 0; m_data = 0; m_n = 0;
        e_data = IDLE_W; e_k = 4'h0; e_al = 0; e_dm = 0;
      end else if (!m_active) begin
        m_active = 1; m_n = 0;
        e_data = IDLE_W; e_k = 4'h0; e_al = 1; e_dm = 0;
      end else begin
        if (m_n == 0) begin
          e_data = COMMA; e_k = 4'b0001;
        end else if (m_data && tvalid) begin
          e_data = tdata; e_k = 4'h0; m_took = 1;
        end else begin
          e_data = IDLE_W; e_k = 4'h0;
        end
        if (!m_data && ad && m_n == P - 1) m_data = 1;
        m_n  = (m_n + 1) % P;
        e_al = !m_data;
        e_dm = m_data;
      end
    end
  end

  task automatic test_reset;
    en = 1; rdy = 1; ad = 0; tvalid = 0; tdata = '0;
    en2 = 0; rdy2 = 1; ad2 = 0; tvalid2 = 0; tdata2 = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {IDLE_W, 4'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got data=%h k=%h rdy=%b al=%b dm=%b, expected all idle/zero",
               o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode);
    end
    rst_n = 1;
  endtask

  task automatic test_align_sequence;
    repeat (2 * P + 2) begin
      @(negedge clk);
      checks++;
      if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {e_data, e_k, e_rdy, e_al, e_dm}) begin
        errors++;
        $display("FAIL align_seq: got data=%h k=%h rdy=%b al=%b dm=%b expected data=%h k=%h rdy=%b al=%b dm=%b",
                 o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode, e_data, e_k, e_rdy, e_al, e_dm);
      end
    end
  endtask

  task automatic test_align_done;
    int n;
    n = 0;
    while (m_n != 2 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    ad = 1;
    n = 0;
    while (!o_data_mode && n < 3 * P) begin
      @(negedge clk);
      n++;
      checks++;
      if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {e_data, e_k, e_rdy, e_al, e_dm}) begin
        errors++;
        $display("FAIL align_done_seq: got data=%h k=%h rdy=%b al=%b dm=%b expected data=%h k=%h rdy=%b al=%b dm=%b",
                 o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode, e_data, e_k, e_rdy, e_al, e_dm);
      end
    end
    // raised during slot 2: edges leave slots 2,3,4,5 before DATA is visible
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL data_mode_latency: got %0d cycles, expected 4", n);
    end
    @(negedge clk);
    checks++;
    if (o_tx_data !== COMMA || o_tx_charisk !== 4'b0001) begin
      errors++;
      $display("FAIL first_data_word: got data=%h k=%h, expected data=%h k=1", o_tx_data, o_tx_charisk, COMMA);
    end
  endtask

  task automatic test_stream;
    logic [31:0] cur, last_out;
    int lows;
    cur = 32'd1; last_out = 32'd0; lows = 0;
    tvalid = 1; tdata = cur;
    repeat (4 * P) begin
      @(negedge clk);
      checks++;
      if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {e_data, e_k, e_rdy, e_al, e_dm}) begin
        errors++;
        $display("FAIL stream_seq: got data=%h k=%h rdy=%b al=%b dm=%b expected data=%h k=%h rdy=%b al=%b dm=%b",
                 o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode, e_data, e_k, e_rdy, e_al, e_dm);
      end
      if (o_tx_charisk == 4'h0) begin
        checks++;
        if (o_tx_data !== last_out + 32'd1) begin
          errors++;
          $display("FAIL stream_order: got %h, expected %h", o_tx_data, last_out + 32'd1);
        end
        last_out = o_tx_data;
      end
      if (!o_tx_tready) lows++;
      if (m_took) cur = cur + 32'd1;
      tdata = cur;
    end
    checks++;
    if (lows != 4) begin
      errors++;
      $display("FAIL tready_low_count: got %0d, expected 4", lows);
    end
  endtask

  task automatic test_toggle;
    repeat (5 * P) begin
      @(negedge clk);
      checks++;
      if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {e_data, e_k, e_rdy, e_al, e_dm}) begin
        errors++;
        $display("FAIL toggle_seq: got data=%h k=%h rdy=%b al=%b dm=%b expected data=%h k=%h rdy=%b al=%b dm=%b",
                 o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode, e_data, e_k, e_rdy, e_al, e_dm);
      end
      // a new word is presented only once the previous one has been taken
      if (!tvalid || m_took) begin
        tvalid = 1'($urandom_range(0, 1));
        tdata  = $urandom | 32'h0000_0100;
      end
    end
    tvalid = 0;
  endtask

  task automatic test_abort;
    int n;
    n = 0;
    while (m_n != 3 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    rdy = 0;
    #1;
    checks++;
    if (o_tx_tready !== 1'b0) begin
      errors++;
      $display("FAIL abort_tready: got %b, expected 0", o_tx_tready);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {IDLE_W, 4'h0, 3'b000}) begin
        errors++;
        $display("FAIL abort_idle: got data=%h k=%h rdy=%b al=%b dm=%b, expected idle/zero",
                 o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode);
      end
    end
    rdy = 1;
    repeat (2 * P + 3) begin
      @(negedge clk);
      checks++;
      if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {e_data, e_k, e_rdy, e_al, e_dm}) begin
        errors++;
        $display("FAIL restore_seq: got data=%h k=%h rdy=%b al=%b dm=%b expected data=%h k=%h rdy=%b al=%b dm=%b",
                 o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode, e_data, e_k, e_rdy, e_al, e_dm);
      end
    end
  endtask

  task automatic test_async_reset;
    int n;
    n = 0;
    tvalid = 1; tdata = 32'hA5A5_0001;
    while (!(m_data && m_n == 3) && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode} !== {IDLE_W, 4'h0, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: got data=%h k=%h rdy=%b al=%b dm=%b, expected idle/zero",
               o_tx_data, o_tx_charisk, o_tx_tready, o_aligning, o_data_mode);
    end
    @(negedge clk);
    rst_n = 1;
    tvalid = 0;
  endtask

  // Far-end aligner: slides one position per received word until the
  // comma lands on the boundary, then needs two period-spaced commas.
  task automatic test_long_period;
    int  off, slides, good, gap, data_commas, bad_gaps;
    bit  aligned, seen, is_comma;
    off = $urandom_range(0, 39);
    slides = 0; good = 0; gap = 0; data_commas = 0; bad_gaps = 0;
    aligned = 0; seen = 0;
    en2 = 1;
    for (int cyc = 0; cyc < 12000 && data_commas < 3; cyc++) begin
      @(negedge clk);
      gap++;
      is_comma = (o2_tx_charisk == 4'b0001) && (o2_tx_data == COMMA);
      if (o2_tx_charisk != 4'h0 && !is_comma) begin
        checks++; errors++;
        $display("FAIL long_bad_k: got data=%h k=%h, expected comma or k=0", o2_tx_data, o2_tx_charisk);
      end
      if (is_comma) begin
        if (seen) begin
          checks++;
          if (gap != 1024) begin
            errors++; bad_gaps++;
            $display("FAIL long_comma_gap: got %0d, expected 1024", gap);
          end
        end
        seen = 1; gap = 0;
        if (o2_data_mode) data_commas++;
      end
      if (!aligned) begin
        if (off != 0) begin
          off--; slides++;
        end else if (is_comma) begin
          good++;
          if (good == 2) begin aligned = 1; ad2 = 1; end
        end
      end
    end
    checks++;
    if (!aligned || slides > 80) begin
      errors++;
      $display("FAIL long_align: got aligned=%0d slides=%0d, expected aligned=1 slides<=80", aligned, slides);
    end
    checks++;
    if (data_commas < 3) begin
      errors++;
      $display("FAIL long_data_mode: got %0d commas in DATA, expected 3", data_commas);
    end
    en2 = 0;
  endtask

  initial begin
    test_reset();
    test_align_sequence();
    test_align_done();
    test_stream();
    test_toggle();
    test_abort();
    test_async_reset();
    test_align_sequence();
    test_long_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
